shake_squeeze_stream: RTL and testbench

//  Multi-block SHAKE squeeze engine: streams an arbitrary-length XOF output as OUT_W-bit words.

---
 rtl/shake_squeeze_stream_pkg.sv | 14 +
 rtl/shake_squeeze_stream_if.sv | 17 +
 rtl/shake_rate_shreg.sv | 26 ++
 rtl/shake_squeeze_stream.sv | 129 ++++++++++++
 tb/tb_shake_squeeze_stream.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/shake_squeeze_stream_pkg.sv
// Shared constants and FSM state type for the SHAKE squeeze engine.
// Optional byte-length mode is selected with SQUEEZE_BYTE_LEN_EN.
package shake_pkg;
  localparam int KECCAK_STATE_W  = 1600;
  localparam int SHAKE256_RATE_W = 1088;
  localparam int SHAKE128_RATE_W = 1344;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EMIT      = 2'd1,
    PERM_WAIT = 2'd2,
    DONE      = 2'd3
  } squeeze_state_t;
endpackage

// File: rtl/shake_squeeze_stream_if.sv
// Output word stream of the SHAKE squeeze engine (valid/ready with last marker).
// out_keep exists only when SQUEEZE_BYTE_LEN_EN is defined.
interface shake_squeeze_stream_if #(parameter int OUT_W = 64);
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
`ifdef SQUEEZE_BYTE_LEN_EN
  logic [OUT_W/8-1:0] out_keep;

  modport master (output out_data, out_valid, out_last, out_keep, input out_ready);
  modport slave  (input out_data, out_valid, out_last, out_keep, output out_ready);
`else
  modport master (output out_data, out_valid, out_last, input out_ready);
  modport slave  (input out_data, out_valid, out_last, output out_ready);
`endif
endinterface

// File: rtl/shake_rate_shreg.sv
// Rate-portion holding register: parallel load of a permuted block, shift right by one word.
module shake_rate_shreg #(
  parameter int RATE_W = 1088,
  parameter int OUT_W  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [RATE_W-1:0] i_data,
  input  logic              i_shift,
  output logic [OUT_W-1:0]  o_word
);
  logic [RATE_W-1:0] r_rate;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rate <= '0;
    end else if (i_load) begin
      r_rate <= i_data;
    end else if (i_shift) begin
      r_rate <= {{OUT_W{1'b0}}, r_rate[RATE_W-1:OUT_W]};
    end
  end

  assign o_word = r_rate[OUT_W-1:0];
endmodule

// File: rtl/shake_squeeze_stream.sv
// SHAKE squeeze engine: streams XOF output words, requesting a permutation per exhausted block.
// Define SQUEEZE_BYTE_LEN_EN to take out_len in bytes and drive out_keep on the final word.
module shake_squeeze_stream
  import shake_pkg::*;
#(
  parameter int STATE_W = 1600,
  parameter int RATE_W  = 1088,
  parameter int OUT_W   = 64,
  parameter int LEN_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   out_len,
  input  logic [STATE_W-1:0] state_in,
  output logic               perm_req,
  input  logic               perm_done,
  output logic               busy,
  output logic               squeeze_done,
  shake_squeeze_stream_if.master out_if
);
  localparam int WPB   = RATE_W / OUT_W;
  localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int BYTES = OUT_W / 8;

  if (STATE_W != KECCAK_STATE_W) begin : g_err_state
    $error("shake_squeeze_stream: STATE_W must be 1600");
  end
  if ((RATE_W % OUT_W) != 0) begin : g_err_rate
    $error("shake_squeeze_stream: RATE_W must be a multiple of OUT_W");
  end
  if ((OUT_W % 8) != 0) begin : g_err_out
    $error("shake_squeeze_stream: OUT_W must be a multiple of 8");
  end

  squeeze_state_t   r_state, w_state_nxt;
  logic [LEN_W-1:0] r_rem;
  logic [IDX_W-1:0] r_idx;
  logic [LEN_W-1:0] w_len_words;
  logic [OUT_W-1:0] w_word;
  logic             w_xfer, w_load, w_blk_end, w_last;
  logic             w_unused_hi;

  assign w_unused_hi = ^state_in[STATE_W-1:RATE_W];
  assign w_xfer      = (r_state == EMIT) && out_if.out_ready;
  assign w_load      = ((r_state == IDLE) && start) || ((r_state == PERM_WAIT) && perm_done);
  assign w_blk_end   = (r_idx == IDX_W'(WPB - 1));
  assign w_last      = (r_rem == LEN_W'(1));

`ifdef SQUEEZE_BYTE_LEN_EN
  logic [LEN_W:0]     w_len_ext;
  logic [LEN_W-1:0]   w_rem_bytes;
  logic [BYTES-1:0]   w_keep_last, r_keep_last;
  assign w_len_ext   = ({1'b0, out_len} + (LEN_W+1)'(BYTES - 1)) / (LEN_W+1)'(BYTES);
  assign w_len_words = LEN_W'(w_len_ext);
  assign w_rem_bytes = out_len % LEN_W'(BYTES);
  always_comb begin
    w_keep_last = '0;
    for (int b = 0; b < BYTES; b++)
      w_keep_last[b] = (w_rem_bytes == '0) || (LEN_W'(b) < w_rem_bytes);
  end
`else
  assign w_len_words = out_len;
`endif

  shake_rate_shreg #(.RATE_W(RATE_W), .OUT_W(OUT_W)) u_shreg (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_data  (state_in[RATE_W-1:0]),
    .i_shift (w_xfer),
    .o_word  (w_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (start) w_state_nxt = (w_len_words == '0) ? DONE : EMIT;
      EMIT:      if (w_xfer) begin
                   if (w_last)         w_state_nxt = DONE;
                   else if (w_blk_end) w_state_nxt = PERM_WAIT;
                 end
      PERM_WAIT: if (perm_done) w_state_nxt = EMIT;
      DONE:      w_state_nxt = IDLE;
      default:   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_idx <= '0;
`ifdef SQUEEZE_BYTE_LEN_EN
      r_keep_last <= '0;
`endif
    end else if ((r_state == IDLE) && start) begin
      r_rem <= w_len_words;
      r_idx <= '0;
`ifdef SQUEEZE_BYTE_LEN_EN
      r_keep_last <= w_keep_last;
`endif
    end else if (w_xfer) begin
      r_rem <= r_rem - LEN_W'(1);
      r_idx <= w_blk_end ? '0 : r_idx + IDX_W'(1);
    end
  end

  always_comb begin
    out_if.out_valid = (r_state == EMIT);
    out_if.out_last  = (r_state == EMIT) && w_last;
    out_if.out_data  = (r_state == EMIT) ? w_word : '0;
    perm_req         = (r_state == PERM_WAIT);
    busy             = (r_state != IDLE);
    squeeze_done     = (r_state == DONE);
`ifdef SQUEEZE_BYTE_LEN_EN
    out_if.out_keep = '0;
    if (r_state == EMIT) begin
      out_if.out_keep = w_last ? r_keep_last : '1;
      for (int b = 0; b < BYTES; b++)
        if (!out_if.out_keep[b]) out_if.out_data[b*8 +: 8] = 8'h00;
    end
`endif
  end
endmodule

// File: tb/tb_shake_squeeze_stream.sv
// Directed bench for shake_squeeze_stream (SHAKE256 rate, 64-bit words).
module tb_shake_squeeze_stream;
  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [15:0]   out_len;
  logic [1599:0] state_in;
  logic          perm_req;
  logic          perm_done;
  logic          busy;
  logic          squeeze_done;
  int            checks = 0;
  int            errors = 0;

  shake_squeeze_stream_if #(.OUT_W(64)) sif ();

  shake_squeeze_stream #(.STATE_W(1600), .RATE_W(1088), .OUT_W(64), .LEN_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .out_len      (out_len),
    .state_in     (state_in),
    .perm_req     (perm_req),
    .perm_done    (perm_done),
    .busy         (busy),
    .squeeze_done (squeeze_done),
    .out_if       (sif.master)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] lane(int b, int i);
    return {16'hC0DE, 16'(b), 16'(i), 16'h1234 ^ 16'(i * 7)};
  endfunction

  function automatic logic [1599:0] mk_state(int b);
    logic [1599:0] s;
    for (int i = 0; i < 25; i++) s[i*64 +: 64] = lane(b, i);
    return s;
  endfunction

  function automatic logic [63:0] keep_mask(logic [7:0] k);
    logic [63:0] m;
    for (int b = 0; b < 8; b++) m[b*8 +: 8] = {8{k[b]}};
    return m;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one squeeze and checks every word, the last marker, permutation count and done pulse.
  task automatic squeeze(int len, int nw, int b0, bit rnd, int lat, bit inj, logic [7:0] kl);
    int k = 0, blk = b0, perms = 0, wcnt = 0, cyc = 0;
    bit prev_req = 0, just = 0, fin = 0, injected = 0, r;
    logic [7:0] ek;
    @(negedge clk);
    start = 1'b1; out_len = 16'(len); state_in = mk_state(b0); sif.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("valid_after_start", sif.out_valid, 1);
    while (!fin && cyc < 3000) begin
      cyc++;
      if (sif.out_valid) begin
        ek = (k == nw - 1) ? kl : 8'hFF;
        chk("data", sif.out_data, lane(blk, k % 17) & keep_mask(ek));
        chk("last", sif.out_last, (k == nw - 1));
`ifdef SQUEEZE_BYTE_LEN_EN
        chk("keep", sif.out_keep, ek);
`endif
      end
      if (squeeze_done) begin
        chk("done_after_last", just, 1);
        chk("done_valid_low", sif.out_valid, 0);
        chk("word_count", k, nw);
        chk("perm_count", perms, (nw - 1) / 17);
        fin = 1;
      end
      just = 0;
      if (perm_req && !prev_req) begin perms++; wcnt = 0; end
      prev_req = perm_req;
      start = 1'b0; perm_done = 1'b0;
      if (perm_req) begin
        chk("perm_valid_low", sif.out_valid, 0);
        wcnt++;
        if (wcnt == lat) begin perm_done = 1'b1; state_in = mk_state(blk); end
      end
      if (inj && !injected && k == 5 && sif.out_valid) begin
        start = 1'b1; out_len = 16'd3; perm_done = 1'b1; state_in = mk_state(99); injected = 1;
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      sif.out_ready = r;
      if (sif.out_valid && r) begin
        k++;
        if (k % 17 == 0) blk++;
        if (k == nw) just = 1;
      end
      @(negedge clk);
    end
    if (!fin) chk("squeeze_timeout", 0, 1);
    chk("idle_busy", busy, 0);
    chk("idle_done", squeeze_done, 0);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; start = 1'b0; out_len = '0; state_in = '0; perm_done = 1'b0;
    sif.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", sif.out_valid, 0);
    chk("rst_data", sif.out_data, 0);
    chk("rst_last", sif.out_last, 0);
    chk("rst_perm_req", perm_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", squeeze_done, 0);
    rst_n = 1'b1;

    squeeze(4, 4, 0, 0, 1, 0, 8'hFF);
    squeeze(17, 17, 1, 0, 1, 0, 8'hFF);
    squeeze(20, 20, 3, 0, 24, 1, 8'hFF);
    squeeze(40, 40, 6, 1, 7, 0, 8'hFF);

    @(negedge clk);
    start = 1'b1; out_len = 16'd0; state_in = mk_state(50);
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", squeeze_done, 1);
    chk("zero_valid", sif.out_valid, 0);
    chk("zero_perm", perm_req, 0);
    @(negedge clk);
    chk("zero_done_pulse", squeeze_done, 0);
    chk("zero_busy", busy, 0);
    chk("zero_valid2", sif.out_valid, 0);

    start = 1'b1; out_len = 16'd20; state_in = mk_state(10); sif.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!perm_req && cyc < 100) begin cyc++; @(negedge clk); end
    chk("reach_perm_wait", perm_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_perm_req", perm_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_valid", sif.out_valid, 0);
    chk("abort_data", sif.out_data, 0);
    chk("abort_last", sif.out_last, 0);
    chk("abort_done", squeeze_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    squeeze(1, 1, 20, 0, 1, 0, 8'hFF);

`ifdef SQUEEZE_BYTE_LEN_EN
    squeeze(37, 5, 30, 0, 1, 0, 8'h1F);
    squeeze(16, 2, 31, 1, 1, 0, 8'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
